// File: rtl/apu_sample_fetch.sv
// Audio sample fetcher: pulls 64-bit words from memory into a small FIFO and plays them
// out one signed byte per sample_tick. Macro APU_FETCH_UNDERRUN_CNT_EN adds underrun_cnt.
module apu_sample_fetch #(
    parameter int BUF_WORDS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [28:0] base_addr,
    input  logic [15:0] len_words,
    input  logic        loop,
    input  logic        sample_tick,
    output logic [28:0] mem_addr,
    output logic        mem_read_en,
    input  logic [63:0] mem_data,
    input  logic        mem_ack,
    output logic [7:0]  sample,
    output logic        busy,
    output logic        done,
    output logic        underrun
`ifdef APU_FETCH_UNDERRUN_CNT_EN
    ,
    output logic [7:0]  underrun_cnt
`endif
);

    localparam int PTR_W = $clog2(BUF_WORDS);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_WORDS);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d, loop_q, loop_d, fetch_on_q, fetch_on_d;
    logic               done_q, done_d, underrun_q, underrun_d;
    logic [28:0]        base_q, base_d, addr_q, addr_d;
    logic [15:0]        len_q, len_d, fetch_idx_q, fetch_idx_d, play_idx_q, play_idx_d;
    logic [2:0]         byte_ptr_q, byte_ptr_d;
    logic [7:0]         sample_q, sample_d;
    logic [63:0]        buf_q [BUF_WORDS];
    logic [63:0]        buf_d [BUF_WORDS];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
`ifdef APU_FETCH_UNDERRUN_CNT_EN
    logic [7:0]         ucnt_q, ucnt_d;
`endif

    logic        start_acc, push, pop, tick_play, tick_under;
    logic [63:0] cur_word;
    logic [7:0]  cur_byte;

    assign start_acc  = start & ~busy_q;
    assign push       = (state_q == S_REQ) & mem_ack;
    assign tick_play  = busy_q & sample_tick & (count_q != '0);
    assign tick_under = busy_q & sample_tick & (count_q == '0);
    assign pop        = tick_play & (byte_ptr_q == 3'd7);
    assign cur_word   = buf_q[rd_ptr_q];
    assign cur_byte   = cur_word[{byte_ptr_q, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            loop_q      <= 1'b0;
            fetch_on_q  <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            base_q      <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            fetch_idx_q <= '0;
            play_idx_q  <= '0;
            byte_ptr_q  <= '0;
            sample_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < BUF_WORDS; i++) buf_q[i] <= '0;
`ifdef APU_FETCH_UNDERRUN_CNT_EN
            ucnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            loop_q      <= loop_d;
            fetch_on_q  <= fetch_on_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            fetch_idx_q <= fetch_idx_d;
            play_idx_q  <= play_idx_d;
            byte_ptr_q  <= byte_ptr_d;
            sample_q    <= sample_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            buf_q       <= buf_d;
`ifdef APU_FETCH_UNDERRUN_CNT_EN
            ucnt_q      <= ucnt_d;
`endif
        end
    end

    // Start jumps straight to REQ so the first read appears the cycle after start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if ((start_acc && len_words != '0) ||
                        (busy_q && fetch_on_q && count_q < FULL)) state_d = S_REQ;
            S_REQ:  if (mem_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_read_en = (state_q == S_REQ);
        mem_addr    = addr_q;
    end

    always_comb begin
        busy_d      = busy_q;
        loop_d      = loop_q;
        fetch_on_d  = fetch_on_q;
        done_d      = 1'b0;
        underrun_d  = underrun_q;
        base_d      = base_q;
        addr_d      = addr_q;
        len_d       = len_q;
        fetch_idx_d = fetch_idx_q;
        play_idx_d  = play_idx_q;
        byte_ptr_d  = byte_ptr_q;
        sample_d    = sample_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        buf_d       = buf_q;
`ifdef APU_FETCH_UNDERRUN_CNT_EN
        ucnt_d      = ucnt_q;
`endif
        if (start_acc) begin
            base_d      = base_addr;
            addr_d      = base_addr;
            len_d       = len_words;
            loop_d      = loop;
            fetch_idx_d = '0;
            play_idx_d  = '0;
            byte_ptr_d  = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            underrun_d  = 1'b0;
            fetch_on_d  = (len_words != '0);
            busy_d      = (len_words != '0);
            done_d      = (len_words == '0);
`ifdef APU_FETCH_UNDERRUN_CNT_EN
            ucnt_d      = '0;
`endif
        end else begin
            if (push) begin
                buf_d[wr_ptr_q] = mem_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                if (fetch_idx_q == len_q - 16'd1) begin
                    if (loop_q) begin
                        addr_d      = base_q;
                        fetch_idx_d = '0;
                    end else begin
                        fetch_on_d  = 1'b0;
                    end
                end else begin
                    addr_d      = addr_q + 29'd1;
                    fetch_idx_d = fetch_idx_q + 16'd1;
                end
            end
            if (tick_play) begin
                sample_d   = cur_byte;
                byte_ptr_d = byte_ptr_q + 3'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (play_idx_q == len_q - 16'd1) begin
                    if (loop_q) begin
                        play_idx_d = '0;
                    end else begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end else begin
                    play_idx_d = play_idx_q + 16'd1;
                end
            end
            if (tick_under) begin
                sample_d   = 8'h00;
                underrun_d = 1'b1;
`ifdef APU_FETCH_UNDERRUN_CNT_EN
                if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
`endif
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    assign sample   = sample_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;
`ifdef APU_FETCH_UNDERRUN_CNT_EN
    assign underrun_cnt = ucnt_q;
`endif

endmodule
